// File: rtl/systolic_feeder.sv
// systolic_feeder: transmit-side front end for the FP-INT systolic array.
// Accepts whole vectors (N activations + N weights) over valid/ready, holds
// each activation vector for `precision` cycles while shifting the weights
// out MSB-first, counts the tile, waits for the array's done and reports it.
module systolic_feeder #(
   parameter int ACT_WIDTH = 16,
   parameter int W_MAX     = 8,
   parameter int N         = 2,
   parameter int LEN_WIDTH = 12
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [3:0]             precision,
   input  logic [LEN_WIDTH-1:0]   tile_len,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [N*ACT_WIDTH-1:0] s_act,
   input  logic [N*W_MAX-1:0]     s_w,
   input  logic                   sa_done,
   output logic                   active,
   output logic [N*ACT_WIDTH-1:0] act_in,
   output logic [N-1:0]           w_in,
   output logic                   busy,
   output logic                   tile_done,
   output logic                   err
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_DRAIN  = 2'd2;
   localparam int         BW       = (W_MAX > 1) ? $clog2(W_MAX) : 1;

   logic [1:0]             state;
   logic [3:0]             p_reg;
   logic [LEN_WIDTH-1:0]   l_reg;
   logic [LEN_WIDTH-1:0]   acc_cnt;
   logic [LEN_WIDTH-1:0]   emit_cnt;
   logic [3:0]             k;
   logic                   cur_full;
   logic                   nxt_full;
   logic [N*ACT_WIDTH-1:0] cur_act;
   logic [N*ACT_WIDTH-1:0] nxt_act;
   logic [N*W_MAX-1:0]     cur_w;
   logic [N*W_MAX-1:0]     nxt_w;
   logic                   hs;
   logic                   last_slot;
   logic                   start_ok;
   logic [3:0]             bit_idx;
   logic [N-1:0]           w_bits;
   logic [W_MAX-1:0]       col;

   // Staging slot is free and the tile still needs vectors.
   assign s_ready   = (state == S_STREAM) && !nxt_full && (acc_cnt < l_reg);
   assign hs        = s_valid & s_ready;
   assign last_slot = cur_full && (k == p_reg - 4'd1);
   assign busy      = (state == S_STREAM) || (state == S_DRAIN);
   assign start_ok  = (precision != 4'd0) && (int'(precision) <= W_MAX)
                      && (tile_len != '0);

   // Select the current weight bit (MSB-first within the latched precision) per column.
   always_comb begin
      // NOTE: every variable gets a value before any branch/loop so no latch is inferred.
      bit_idx = p_reg - 4'd1 - k;
      w_bits  = '0;
      col     = '0;
      for (int j = 0; j < N; j++) begin
         col       = cur_w[j*W_MAX +: W_MAX];
         w_bits[j] = col[bit_idx[BW-1:0]];
      end
   end

   // Control FSM, two-entry vector buffer and registered array-side outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the two buffer entries are plain registers, so they are cleared
         // along with the control state; a reset mid-tile simply drops them.
         state     <= S_IDLE;
         p_reg     <= '0;
         l_reg     <= '0;
         acc_cnt   <= '0;
         emit_cnt  <= '0;
         k         <= '0;
         cur_full  <= 1'b0;
         nxt_full  <= 1'b0;
         cur_act   <= '0;
         nxt_act   <= '0;
         cur_w     <= '0;
         nxt_w     <= '0;
         active    <= 1'b0;
         act_in    <= '0;
         w_in      <= '0;
         tile_done <= 1'b0;
         err       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         err       <= 1'b0;
         tile_done <= 1'b0;
         case (state)
            S_IDLE: begin
               active <= 1'b0;
               if (start) begin
                  if (start_ok) begin
                     p_reg    <= precision;
                     l_reg    <= tile_len;
                     acc_cnt  <= '0;
                     emit_cnt <= '0;
                     k        <= '0;
                     state    <= S_STREAM;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            S_STREAM: begin
               if (hs) acc_cnt <= acc_cnt + LEN_WIDTH'(1);
               if (cur_full) begin
                  active <= 1'b1;
                  act_in <= cur_act;
                  w_in   <= w_bits;
                  if (last_slot) begin
                     k        <= '0;
                     emit_cnt <= emit_cnt + LEN_WIDTH'(1);
                     if (emit_cnt + LEN_WIDTH'(1) == l_reg) state <= S_DRAIN;
                     // Refill CUR without a bubble from NXT or straight from the bus.
                     if (nxt_full) begin
                        cur_act  <= nxt_act;
                        cur_w    <= nxt_w;
                        nxt_full <= 1'b0;
                     end else if (hs) begin
                        cur_act <= s_act;
                        cur_w   <= s_w;
                     end else begin
                        cur_full <= 1'b0;
                     end
                  end else begin
                     k <= k + 4'd1;
                     if (hs) begin
                        nxt_act  <= s_act;
                        nxt_w    <= s_w;
                        nxt_full <= 1'b1;
                     end
                  end
               end else begin
                  // Stall: no vector to emit, outputs other than active hold.
                  active <= 1'b0;
                  if (hs) begin
                     cur_act  <= s_act;
                     cur_w    <= s_w;
                     cur_full <= 1'b1;
                     k        <= '0;
                  end
               end
            end
            S_DRAIN: begin
               active <= 1'b0;
               if (sa_done) begin
                  tile_done <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: a scoreboard queue holds the
// expected (act_in, w_in) of every active slot, a monitor pops it on the
// falling edge; illegal starts come from a vector table.
module tb_systolic_feeder;

   localparam int ACT_WIDTH = 16;
   localparam int W_MAX     = 8;
   localparam int N         = 2;
   localparam int LEN_WIDTH = 12;

   logic                   clk;
   logic                   rst;
   logic                   start;
   logic [3:0]             precision;
   logic [LEN_WIDTH-1:0]   tile_len;
   logic                   s_valid;
   logic                   s_ready;
   logic [N*ACT_WIDTH-1:0] s_act;
   logic [N*W_MAX-1:0]     s_w;
   logic                   sa_done;
   logic                   active;
   logic [N*ACT_WIDTH-1:0] act_in;
   logic [N-1:0]           w_in;
   logic                   busy;
   logic                   tile_done;
   logic                   err;

   systolic_feeder #(
      .ACT_WIDTH(ACT_WIDTH), .W_MAX(W_MAX), .N(N), .LEN_WIDTH(LEN_WIDTH)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .precision(precision),
      .tile_len(tile_len), .s_valid(s_valid), .s_ready(s_ready),
      .s_act(s_act), .s_w(s_w), .sa_done(sa_done), .active(active),
      .act_in(act_in), .w_in(w_in), .busy(busy), .tile_done(tile_done),
      .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N*ACT_WIDTH-1:0] act;
      logic [N-1:0]           w;
   } slot_t;

   typedef struct {
      logic [3:0]           prec;
      logic [LEN_WIDTH-1:0] len;
      logic                 exp_err;
      logic                 exp_busy;
   } start_vec_t;

   slot_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   int    act_total = 0;
   int    first_act = -1;
   int    last_act = -1;
   int    td_cnt = 0;
   bit    mon_en = 1'b0;

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_mon();
      act_total = 0;
      first_act = -1;
      last_act  = -1;
      td_cnt    = 0;
   endtask

   // Expected slots for one vector: bit p-1 down to 0 of every column.
   task automatic push_vec(input logic [N*ACT_WIDTH-1:0] act, input logic [N*W_MAX-1:0] w, input int p);
      slot_t s;
      for (int k = 0; k < p; k++) begin
         s.act = act;
         for (int j = 0; j < N; j++) s.w[j] = w[j*W_MAX + (p-1-k)];
         exp_q.push_back(s);
      end
   endtask

   task automatic do_start(input logic [3:0] p, input logic [LEN_WIDTH-1:0] l);
      start     = 1'b1;
      precision = p;
      tile_len  = l;
      tick();
      start     = 1'b0;
   endtask

   // Presents one vector and waits (bounded) for its handshake; leaves s_valid high.
   task automatic send_vec(input logic [N*ACT_WIDTH-1:0] act, input logic [N*W_MAX-1:0] w, input int p);
      bit ok;
      ok      = 1'b0;
      s_valid = 1'b1;
      s_act   = act;
      s_w     = w;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (s_ready) begin
            push_vec(act, w, p);
            ok = 1'b1;
         end
         tick();
      end
      if (!ok) check("handshake_timeout", 64'(ok), 64'd1);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      check("drain_timeout_pending", 64'(exp_q.size()), 64'd0);
      check("busy_in_drain", 64'(busy), 64'd1);
      check("s_ready_in_drain", 64'(s_ready), 64'd0);
      check("active_in_drain", 64'(active), 64'd0);
   endtask

   task automatic finish_tile();
      sa_done = 1'b1;
      tick();
      sa_done = 1'b0;
      check("tile_done_after_sa_done", 64'(tile_done), 64'd1);
      check("busy_after_done", 64'(busy), 64'd0);
      tick();
      check("tile_done_one_cycle", 64'(tile_done), 64'd0);
   endtask

   // Monitor: compare every active slot against the scoreboard.
   always @(negedge clk) begin
      slot_t s;
      cyc++;
      if (tile_done) td_cnt++;
      if (mon_en && active) begin
         act_total++;
         if (first_act < 0) first_act = cyc;
         last_act = cyc;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_active: active=1 with empty scoreboard (t=%0t)", $time);
         end else begin
            s = exp_q.pop_front();
            check("act_in", 64'(act_in), 64'(s.act));
            check("w_in", 64'(w_in), 64'(s.w));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      start_vec_t tbl[4];
      tbl[0] = '{prec: 4'd0, len: 12'd5, exp_err: 1'b1, exp_busy: 1'b0};
      tbl[1] = '{prec: 4'd4, len: 12'd0, exp_err: 1'b1, exp_busy: 1'b0};
      tbl[2] = '{prec: 4'd9, len: 12'd3, exp_err: 1'b1, exp_busy: 1'b0};
      tbl[3] = '{prec: 4'd15, len: 12'd1, exp_err: 1'b1, exp_busy: 1'b0};

      rst = 1'b1; start = 1'b0; precision = '0; tile_len = '0;
      s_valid = 1'b0; s_act = '0; s_w = '0; sa_done = 1'b0;
      #1;
      check("reset_s_ready", 64'(s_ready), 64'd0);
      check("reset_active", 64'(active), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_tile_done", 64'(tile_done), 64'd0);
      check("reset_err", 64'(err), 64'd0);
      check("reset_w_in", 64'(w_in), 64'd0);
      check("reset_act_in", 64'(act_in), 64'd0);
      tick(); tick();
      rst = 1'b0;
      mon_en = 1'b1;
      tick();

      // Illegal starts from the table.
      for (int i = 0; i < 4; i++) begin
         do_start(tbl[i].prec, tbl[i].len);
         check($sformatf("illegal%0d_err", i), 64'(err), 64'(tbl[i].exp_err));
         check($sformatf("illegal%0d_busy", i), 64'(busy), 64'(tbl[i].exp_busy));
         check($sformatf("illegal%0d_s_ready", i), 64'(s_ready), 64'd0);
         tick();
         check($sformatf("illegal%0d_err_pulse", i), 64'(err), 64'd0);
      end

      // Basic tile: P=4, L=1.
      reset_mon();
      do_start(4'd4, 12'd1);
      check("basic_busy", 64'(busy), 64'd1);
      send_vec({16'h3C00, 16'h4000}, {8'b1111_1010, 8'b0101_0011}, 4);
      s_valid = 1'b0;
      check("basic_latency_1", 64'(active), 64'd0);
      tick();
      check("basic_latency_2", 64'(active), 64'd1);
      wait_drain();
      check("basic_active_cycles", 64'(act_total), 64'd4);
      finish_tile();
      check("basic_tile_done_count", 64'(td_cnt), 64'd1);

      // Back-to-back: P=3, L=3; mid-tile precision/tile_len changes are ignored.
      reset_mon();
      do_start(4'd3, 12'd3);
      precision = 4'd7;
      tile_len  = 12'd1;
      send_vec({16'h1111, 16'h2222}, {8'hA5, 8'h3C}, 3);
      send_vec({16'h3333, 16'h4444}, {8'h06, 8'hF1}, 3);
      send_vec({16'h5555, 16'h6666}, {8'h5B, 8'h02}, 3);
      check("b2b_s_ready_after_3rd", 64'(s_ready), 64'd0);
      s_valid = 1'b0;
      wait_drain();
      check("b2b_active_cycles", 64'(act_total), 64'd9);
      check("b2b_no_gap", 64'(last_act - first_act + 1), 64'd9);
      finish_tile();

      // Upstream stall: P=2, L=2, second vector delayed.
      reset_mon();
      do_start(4'd2, 12'd2);
      send_vec({16'hBEEF, 16'hCAFE}, {8'hF2, 8'h01}, 2);
      s_valid = 1'b0;
      sa_done = 1'b1;
      repeat (5) tick();
      sa_done = 1'b0;
      check("stall_active", 64'(active), 64'd0);
      check("stall_act_in_held", 64'(act_in), 64'({16'hBEEF, 16'hCAFE}));
      check("stall_w_in_held", 64'(w_in), 64'(2'b01));
      check("stall_busy", 64'(busy), 64'd1);
      check("stall_no_tile_done", 64'(td_cnt), 64'd0);
      send_vec({16'h0F0F, 16'hF0F0}, {8'h03, 8'hFE}, 2);
      s_valid = 1'b0;
      wait_drain();
      check("stall_active_cycles", 64'(act_total), 64'd4);
      finish_tile();

      // Drain ordering: sa_done (and a rejected-looking start) during STREAM are ignored.
      reset_mon();
      do_start(4'd2, 12'd1);
      send_vec({16'h7777, 16'h8888}, {8'h02, 8'h01}, 2);
      s_valid   = 1'b0;
      sa_done   = 1'b1;
      start     = 1'b1;
      precision = 4'd0;
      tile_len  = 12'd0;
      tick();
      sa_done = 1'b0;
      start   = 1'b0;
      check("drain_stream_sa_done_ignored", 64'(tile_done), 64'd0);
      check("start_while_busy_no_err", 64'(err), 64'd0);
      wait_drain();
      check("drain_no_early_tile_done", 64'(td_cnt), 64'd0);
      finish_tile();
      check("drain_tile_done_count", 64'(td_cnt), 64'd1);

      // Reset during the 2nd bit of a P=4 vector.
      reset_mon();
      do_start(4'd4, 12'd2);
      send_vec({16'h9999, 16'hAAAA}, {8'h0F, 8'h0F}, 4);
      tick();
      tick();
      check("rst_mid_active_before", 64'(active), 64'd1);
      mon_en = 1'b0;
      rst    = 1'b1;
      #1;
      check("rst_mid_active", 64'(active), 64'd0);
      check("rst_mid_w_in", 64'(w_in), 64'd0);
      check("rst_mid_s_ready", 64'(s_ready), 64'd0);
      check("rst_mid_busy", 64'(busy), 64'd0);
      exp_q.delete();
      s_valid = 1'b0;
      tick();
      rst    = 1'b0;
      mon_en = 1'b1;
      tick();
      tick();
      check("rst_mid_no_tile_done", 64'(td_cnt), 64'd0);
      check("rst_mid_active_after", 64'(active), 64'd0);
      reset_mon();
      do_start(4'd4, 12'd1);
      send_vec({16'h1234, 16'h5678}, {8'hC9, 8'h36}, 4);
      s_valid = 1'b0;
      wait_drain();
      check("rst_restart_active_cycles", 64'(act_total), 64'd4);
      finish_tile();

      // P=1: one vector per cycle.
      reset_mon();
      do_start(4'd1, 12'd4);
      send_vec({16'h0001, 16'h0002}, {8'hFF, 8'h00}, 1);
      send_vec({16'h0003, 16'h0004}, {8'h00, 8'hFF}, 1);
      send_vec({16'h0005, 16'h0006}, {8'hFF, 8'hFF}, 1);
      send_vec({16'h0007, 16'h0008}, {8'hFE, 8'hFE}, 1);
      s_valid = 1'b0;
      wait_drain();
      check("p1_active_cycles", 64'(act_total), 64'd4);
      check("p1_no_gap", 64'(last_act - first_act + 1), 64'd4);
      finish_tile();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Transmit-side front end for the FP-INT systolic array.
- Accepts whole input vectors from the upstream buffer over a valid/ready handshake: N activations plus N integer weights.
- Drives the array's `active`, `act_in` and bit-serial `w_in` inputs, holding each activation vector for `precision` cycles while serialising weights MSB-first.
- Tracks the tile length, waits for the array's `done`, then reports tile completion upstream.

Parameters:
- ACT_WIDTH, 16, activation word width (FP16 payload).
- W_MAX, 8, maximum weight precision in bits; also the storage width per weight.
- N, 2, array dimension (rows of activations, columns of weights).
- LEN_WIDTH, 12, width of the tile-length counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse, begins a tile; sampled only in IDLE
- precision  in  4  weight bits per vector, legal 1..W_MAX; latched on accepted start
- tile_len  in  LEN_WIDTH  vectors in the tile, legal >=1; latched on accepted start
- s_valid  in  1  upstream vector valid
- s_ready  out  1  feeder can accept a vector this cycle
- s_act  in  N*ACT_WIDTH  activations, row i at bits [i*ACT_WIDTH +: ACT_WIDTH]
- s_w  in  N*W_MAX  weights, column j at bits [j*W_MAX +: W_MAX], two's complement, right-aligned to precision
- sa_done  in  1  array completion (done of last PE)
- active  out  1  to array: current bit slot valid
- act_in  out  N*ACT_WIDTH  to array: activations held for the whole vector
- w_in  out  N  to array: current weight bit per column
- busy  out  1  high in STREAM or DRAIN
- tile_done  out  1  one-cycle pulse at tile completion
- err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset (async, rst=1): state IDLE, both buffer entries empty. All outputs are 0, including s_ready.
- All array-side outputs (active, act_in, w_in) are registered.
- States: IDLE -> STREAM -> DRAIN -> IDLE.
- IDLE:
  - s_ready=0.
  - On start with precision in 1..W_MAX and tile_len!=0: latch P and L, clear counters, go STREAM next cycle.
  - On start with precision==0, precision>W_MAX, or tile_len==0: pulse err on the next cycle and stay IDLE.
- Buffer: 2 entries, CUR (being emitted) and NXT (staged).
  - s_ready=1 in STREAM when NXT is empty and the accepted count is below L. It is never asserted in IDLE or DRAIN.
  - A handshake (s_valid & s_ready) writes NXT, or writes CUR directly if CUR is empty and not emitting.
  - Vectors beyond L are never accepted.
- Emission:
  - While CUR is full, each cycle presents bit index b = P-1-k (k = 0..P-1) of every column on w_in, with active=1 and act_in = CUR activations. These appear on the outputs one cycle after the slot is computed.
  - On k==P-1, CUR is released. If NXT is full (or is being written that same cycle), NXT moves to CUR and the next vector begins on the immediately following cycle, with no bubble.
  - If no vector is available: active=0, and w_in/act_in hold their last value (a stall). The stall is legal and is not an error.
- Counters:
  - acc_cnt counts accepted vectors; emit_cnt counts completed vectors.
  - When emit_cnt reaches L, go DRAIN.
- DRAIN:
  - active=0.
  - Wait for sa_done=1.
  - On sa_done, pulse tile_done for 1 cycle and go IDLE.
  - sa_done seen in STREAM is ignored.
- start while busy: ignored, no err.
- precision/tile_len changes mid-tile: no effect; latched values are used.
- Reset mid-tile: immediate return to IDLE. Buffers are dropped, active=0, no tile_done.
- P==1: each vector occupies exactly 1 cycle; back-to-back vectors stream at 1 vector/cycle while s_valid stays high.
- Latency: from first handshake in STREAM, active rises 2 cycles later (1 for the buffer write, 1 for the output register).

Test Plan:
- Basic tile:
  - Stimulus: start, P=4, L=1, N=2, s_w={col1=4'b1010, col0=4'b0011}, act={0x3C00, 0x4000}.
  - Required: active high for exactly 4 cycles; w_in[0] sequence 0,0,1,1; w_in[1] sequence 1,0,1,0; act_in constant; after sa_done, tile_done pulses once and busy drops.
- Back-to-back:
  - Stimulus: P=3, L=3, s_valid held high.
  - Required: active high for 9 consecutive cycles with no gap; act_in changes exactly at cycles 3 and 6; s_ready deasserts after the 3rd accept.
- Upstream stall:
  - Stimulus: P=2, L=2, second vector's s_valid delayed 5 cycles.
  - Required: active=0 during the gap, outputs held; total active-high cycles = 4; tile_done only after sa_done.
- Illegal start:
  - Stimulus: start with precision=0; then start with tile_len=0; then start with precision=9 (W_MAX=8).
  - Required: each produces an err pulse; state stays IDLE; s_ready stays 0.
- Reset mid-operation:
  - Stimulus: assert rst during the 2nd bit of a P=4 vector.
  - Required: active, w_in, s_ready and busy are 0 immediately; no tile_done; a subsequent start streams normally from bit P-1.
- Drain ordering:
  - Stimulus: sa_done pulsed during STREAM, then again in DRAIN.
  - Required: only the DRAIN pulse causes tile_done, and tile_done rises exactly 1 cycle after it.
